mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the team's 4:1 32-bit mux (in1..in4, sel[1:0]) among four requesters. It issues one-hot grants and drives the mux select. It registers the selected word onto a single valid/ready output channel. Bursts of up to MAX_BURST beats per grant are allowed before forced rotation.

---
 rtl/mux4_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter/sequencer in front of a shared 4:1 mux.
// It grants one of four requesters at a time, steers the mux select to the
// winner and registers the accepted word onto a valid/ready output channel.
// A requester may move up to MAX_BURST beats per grant before the grant rotates.
// Every grant passes through one IDLE cycle before the next winner is chosen.
// Optional build macro MUX4_ARB_FIXED_PRIO_EN: the IDLE choice becomes fixed
// priority (req[0] highest) and the rotation pointer is left untouched.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    output logic [3:0]       ack,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Beat index of the final beat a requester may move in one grant.
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t           state_r;
    logic [1:0]       ptr_r;
    logic [3:0]       beat_cnt_r;
    logic [3:0]       grant_r;
    logic [1:0]       sel_r;
    logic [WIDTH-1:0] out_r;
    logic             out_valid_r;

    logic             can_load_s;
    logic             load_s;
    logic [3:0]       ack_s;
    logic [1:0]       winner_s;
    logic [WIDTH-1:0] sel_data_s;

    // Output register can take a new word when it is empty or being drained.
    always_comb begin
        can_load_s = !out_valid_r || out_ready;
        ack_s      = 4'b0000;
        if (state_r == GRANT) begin
            ack_s[sel_r] = req[sel_r] && can_load_s;
        end else begin
            ack_s = 4'b0000;
        end
        load_s = |ack_s;
    end

    // Shared 4:1 mux steered by the registered select.
    always_comb begin
        case (sel_r)
            2'd0:    sel_data_s = in1;
            2'd1:    sel_data_s = in2;
            2'd2:    sel_data_s = in3;
            2'd3:    sel_data_s = in4;
            default: sel_data_s = in1;
        endcase
    end

`ifdef MUX4_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest-numbered active request wins.
    always_comb begin
        if (req[0]) begin
            winner_s = 2'd0;
        end else if (req[1]) begin
            winner_s = 2'd1;
        end else if (req[2]) begin
            winner_s = 2'd2;
        end else begin
            winner_s = 2'd3;
        end
    end
`else
    // Round-robin: first active request scanning upward from ptr, wrapping mod 4.
    always_comb begin
        logic       found_s;
        logic [1:0] idx_s;
        winner_s = ptr_r;
        found_s  = 1'b0;
        idx_s    = ptr_r;
        for (int k = 0; k < 4; k++) begin
            idx_s = ptr_r + 2'(k);
            if (!found_s && req[idx_s]) begin
                winner_s = idx_s;
                found_s  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end
`endif

    // Arbiter FSM plus output channel register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= 2'd0;
            beat_cnt_r  <= 4'd0;
            grant_r     <= 4'b0000;
            sel_r       <= 2'd0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (load_s) begin
                out_r       <= sel_data_s;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            case (state_r)
                IDLE: begin
                    if (|req) begin
                        grant_r    <= 4'b0001 << winner_s;
                        sel_r      <= winner_s;
                        beat_cnt_r <= 4'd0;
                        state_r    <= GRANT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    // Release on the last allowed beat or when the owner withdraws.
                    if ((load_s && (beat_cnt_r == LAST_BEAT)) || !req[sel_r]) begin
                        grant_r <= 4'b0000;
                        state_r <= IDLE;
`ifndef MUX4_ARB_FIXED_PRIO_EN
                        ptr_r   <= sel_r + 2'd1;
`endif
                    end else begin
                        state_r <= GRANT;
                    end
                    if (load_s) begin
                        beat_cnt_r <= beat_cnt_r + 4'd1;
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= 4'b0000;
                end
            endcase
        end
    end

    assign ack       = ack_s;
    assign grant     = grant_r;
    assign sel       = sel_r;
    assign out       = out_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios followed by randomized
// protocol-legal traffic, all compared against a transaction-level model.
module tb_mux4_rr_arbiter;

    localparam int W  = 32;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [W-1:0] in1, in2, in3, in4;
    logic [3:0]   ack;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;

    int n_vec = 0;
    int n_err = 0;

    // Model: owner of the bus (-1 = nobody), rotation start, beats moved so far.
    int           m_owner = -1;
    int           m_ptr   = 0;
    int           m_sel   = 0;
    int           m_beats = 0;
    logic [W-1:0] m_out   = '0;
    bit           m_valid = 1'b0;
    logic [3:0]   last_ack = 4'b0000;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .ack(ack), .grant(grant), .sel(sel),
        .out(out), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] word_of(input int i);
        case (i)
            0:       return in1;
            1:       return in2;
            2:       return in3;
            default: return in4;
        endcase
    endfunction

    function automatic logic [3:0] model_ack();
        if (m_owner >= 0 && req[m_owner] && (!m_valid || out_ready))
            return 4'(1 << m_owner);
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_sel = 0; m_beats = 0;
        m_out = '0; m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] a);
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        if (a != 4'b0000) begin
            m_out = word_of(m_owner);
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (m_owner < 0) begin
            if (req != 4'b0000) begin
                w = -1;
`ifdef MUX4_ARB_FIXED_PRIO_EN
                for (int k = 3; k >= 0; k--) if (req[k]) w = k;
`else
                for (int k = 3; k >= 0; k--) if (req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
`endif
                m_owner = w; m_sel = w; m_beats = 0;
            end
        end else begin
            if (a != 4'b0000) m_beats++;
            if ((a != 4'b0000 && m_beats == MB) || !req[m_owner]) begin
`ifndef MUX4_ARB_FIXED_PRIO_EN
                m_ptr = (m_sel + 1) % 4;
`endif
                m_owner = -1;
            end
        end
    endtask

    // One clock: check comb ack mid-cycle, advance model at the edge, check registers.
    task automatic step();
        logic [3:0] ea;
        @(negedge clk);
        #1;
        ea = model_ack();
        chk("ack", W'(ack), W'(ea));
        @(posedge clk);
        model_edge(ea);
        #1;
        chk("grant", W'(grant), (m_owner < 0) ? '0 : W'(1 << m_owner));
        chk("sel", W'(sel), W'(m_sel));
        chk("out_valid", W'(out_valid), W'(m_valid));
        chk("out", out, m_out);
        last_ack = ea;
    endtask

    // Acked requesters either present a fresh word or withdraw.
    task automatic retire_acked(input bit keep);
        for (int i = 0; i < 4; i++) begin
            if (last_ack[i]) begin
                if (keep) begin
                    case (i)
                        0: in1 = $urandom;
                        1: in2 = $urandom;
                        2: in3 = $urandom;
                        default: in4 = $urandom;
                    endcase
                end else begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; out_ready = 1'b1;
        in1 = '0; in2 = '0; in3 = '0; in4 = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_grant", W'(grant), '0);
        chk("rst_sel", W'(sel), '0);
        chk("rst_out", out, '0);
        chk("rst_valid", W'(out_valid), '0);
        chk("rst_ack", W'(ack), '0);
        rst = 1'b0;

        // Single requester 2 with word 5.
        in2 = 32'd5; req = 4'b0010;
        step();
        chk("single_grant", W'(grant), 32'h2);
        step();
        chk("single_out", out, 32'd5);
        chk("single_valid", W'(out_valid), 32'd1);
        req = 4'b0000;
        step();
        step();
        chk("single_release", W'(grant), '0);

        // All four contend with fixed words, fresh copy after each ack.
        in1 = 32'd2; in2 = 32'd5; in3 = 32'd8; in4 = 32'd15; req = 4'b1111;
        repeat (24) step();

        // Backpressure while holding a word.
        out_ready = 1'b0;
        repeat (6) step();
        chk("bp_ack", W'(ack), '0);
        out_ready = 1'b1;
        repeat (4) step();

        // Burst between requesters 1 and 3.
        req = 4'b0101;
        repeat (20) step();

        // Reset mid-burst, then full contention must start at requester 1.
        req = 4'b1000;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        step();
        chk("post_rst_sel", W'(sel), 32'd0);

        // Randomized legal traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            retire_acked($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && !last_ack[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1;
                        case (i)
                            0: in1 = $urandom;
                            1: in2 = $urandom;
                            2: in3 = $urandom;
                            default: in4 = $urandom;
                        endcase
                    end
                end else if (req[i] && !last_ack[i] && $urandom_range(0, 40) == 0) begin
                    req[i] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
